// File: rtl/md5_pad_feeder.sv
// MD5 message padder: packs a byte stream into 512-bit blocks with 0x80 marker,
// zero fill and a little-endian bit length. Define MD5_PAD_FULL_LEN_EN for a 61-bit byte counter.
module md5_pad_feeder (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

`ifdef MD5_PAD_FULL_LEN_EN
    localparam int CNT_W = 61;
`else
    localparam int CNT_W = 29;
`endif

    typedef enum logic [1:0] {FILL, PAD, EMIT, EXTRA} state_t;

    state_t           state;
    logic [6:0]       idx;
    logic [CNT_W-1:0] byte_cnt;
    logic             final_q;
    logic             to_extra;
    logic             extra_mark;
    logic             first_q;
    logic [63:0]      bit_len;
    logic [511:0]     pad_blk;
    logic [511:0]     extra_blk;
    logic             accept;

    assign bit_len = 64'({byte_cnt, 3'b000});
    assign accept  = in_valid && in_ready;

    // Bytes past the marker may hold stale data from an earlier non-final block, so zero them here.
    always_comb begin
        pad_blk = blk_data;
        for (int k = 0; k < 64; k++) begin
            if (7'(k) == idx)
                pad_blk[8*k +: 8] = 8'h80;
            else if (7'(k) > idx)
                pad_blk[8*k +: 8] = 8'h00;
        end
        if (idx <= 7'd55)
            pad_blk[511:448] = bit_len;
    end

    always_comb begin
        extra_blk          = {bit_len, 448'b0};
        extra_blk[7:0]     = extra_mark ? 8'h80 : 8'h00;
    end

    // NOTE: all state here is sequential, so every assignment in this block is non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            idx        <= '0;
            byte_cnt   <= '0;
            blk_data   <= '0;
            in_ready   <= 1'b1;
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            final_q    <= 1'b0;
            to_extra   <= 1'b0;
            extra_mark <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (in_empty) begin
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end else begin
                            blk_data[{idx[5:0], 3'b000} +: 8] <= in_data;
                            idx      <= idx + 7'd1;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (in_last) begin
                                state    <= PAD;
                                in_ready <= 1'b0;
                            end else if (idx == 7'd63) begin
                                state     <= EMIT;
                                in_ready  <= 1'b0;
                                blk_valid <= 1'b1;
                                blk_first <= first_q;
                                blk_last  <= 1'b0;
                                final_q   <= 1'b0;
                                to_extra  <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    blk_data   <= pad_blk;
                    state      <= EMIT;
                    blk_valid  <= 1'b1;
                    blk_first  <= first_q;
                    final_q    <= (idx <= 7'd55);
                    blk_last   <= (idx <= 7'd55);
                    to_extra   <= (idx > 7'd55);
                    extra_mark <= (idx == 7'd64);
                end
                EXTRA: begin
                    blk_data  <= extra_blk;
                    state     <= EMIT;
                    blk_valid <= 1'b1;
                    blk_first <= first_q;
                    blk_last  <= 1'b1;
                    final_q   <= 1'b1;
                    to_extra  <= 1'b0;
                end
                EMIT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_first <= 1'b0;
                        blk_last  <= 1'b0;
                        first_q   <= final_q;
                        if (final_q) begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                            idx      <= '0;
                            byte_cnt <= '0;
                            blk_data <= '0;
                        end else if (to_extra) begin
                            state <= EXTRA;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                            idx      <= '0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_pad_feeder.sv
// Directed bench for md5_pad_feeder: padding boundaries, stalls and mid-message reset.
module tb_md5_pad_feeder;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    md5_pad_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_empty = 1'b0;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_blk(output int cyc, output bit ok);
        cyc = 0;
        while (!blk_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        ok = (blk_valid === 1'b1);
    endtask

    task automatic take_blk();
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1000", {in_ready, blk_valid, blk_first, blk_last});
        end
        checks++;
        if (blk_data !== 512'b0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", blk_data);
        end
    endtask

    task automatic test_empty();
        logic [511:0] exp;
        int cyc;
        bit ok;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_empty = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        wait_blk(cyc, ok);
        exp = '0;
        exp[7:0] = 8'h80;
        checks++;
        if (!ok || cyc != 1) begin
            errors++;
            $display("FAIL empty_latency: got %0d cycles (valid=%b) want 1", cyc, ok);
        end
        checks++;
        if (blk_data !== exp) begin
            errors++;
            $display("FAIL empty_data: got %h want %h", blk_data, exp);
        end
        checks++;
        if ({blk_first, blk_last} !== 2'b11) begin
            errors++;
            $display("FAIL empty_flags: got %b want 11", {blk_first, blk_last});
        end
        take_blk();
    endtask

    task automatic test_abc(input string tag);
        logic [511:0] exp;
        int cyc;
        bit ok;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b want 1", tag, in_ready);
        end
        send(8'h63, 1'b1);
        checks++;
        if ({in_ready, blk_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s_pad_cycle: got ready/valid %b want 00", tag, {in_ready, blk_valid});
        end
        wait_blk(cyc, ok);
        exp = '0;
        exp[31:0]    = 32'h80636261;
        exp[455:448] = 8'h18;
        checks++;
        if (!ok || cyc != 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (valid=%b) want 1", tag, cyc, ok);
        end
        checks++;
        if (blk_data !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h want %h", tag, blk_data, exp);
        end
        checks++;
        if ({blk_first, blk_last} !== 2'b11) begin
            errors++;
            $display("FAIL %s_flags: got %b want 11", tag, {blk_first, blk_last});
        end
        take_blk();
        checks++;
        if ({blk_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_release: got valid/ready %b want 01", tag, {blk_valid, in_ready});
        end
    endtask

    task automatic test_len55();
        logic [511:0] exp;
        int cyc;
        bit ok;
        exp = '0;
        for (int i = 0; i < 55; i++) begin
            send(8'h41, i == 54);
            exp[8*i +: 8] = 8'h41;
        end
        exp[447:440] = 8'h80;
        exp[455:448] = 8'hB8;
        exp[463:456] = 8'h01;
        wait_blk(cyc, ok);
        checks++;
        if (!ok || blk_data !== exp) begin
            errors++;
            $display("FAIL len55_data: got %h want %h", blk_data, exp);
        end
        checks++;
        if ({blk_first, blk_last} !== 2'b11) begin
            errors++;
            $display("FAIL len55_flags: got %b want 11", {blk_first, blk_last});
        end
        take_blk();
    endtask

    task automatic test_len56();
        logic [511:0] exp;
        int cyc;
        bit ok;
        exp = '0;
        for (int i = 0; i < 56; i++) begin
            send(8'h41, i == 55);
            exp[8*i +: 8] = 8'h41;
        end
        exp[455:448] = 8'h80;
        wait_blk(cyc, ok);
        checks++;
        if (!ok || blk_data !== exp) begin
            errors++;
            $display("FAIL len56_blk1_data: got %h want %h", blk_data, exp);
        end
        checks++;
        if ({blk_first, blk_last} !== 2'b10) begin
            errors++;
            $display("FAIL len56_blk1_flags: got %b want 10", {blk_first, blk_last});
        end
        take_blk();
        wait_blk(cyc, ok);
        exp = '0;
        exp[455:448] = 8'hC0;
        exp[463:456] = 8'h01;
        checks++;
        if (!ok || cyc != 1) begin
            errors++;
            $display("FAIL len56_blk2_latency: got %0d cycles (valid=%b) want 1", cyc, ok);
        end
        checks++;
        if (blk_data !== exp) begin
            errors++;
            $display("FAIL len56_blk2_data: got %h want %h", blk_data, exp);
        end
        checks++;
        if ({blk_first, blk_last} !== 2'b01) begin
            errors++;
            $display("FAIL len56_blk2_flags: got %b want 01", {blk_first, blk_last});
        end
        take_blk();
    endtask

    task automatic test_back_to_back_stall();
        logic [511:0] exp;
        int cyc;
        bit ok;
        exp = '0;
        for (int i = 0; i < 64; i++) begin
            send(8'(i), i == 63);
            exp[8*i +: 8] = 8'(i);
        end
        for (int b = 0; b < 2; b++) begin
            wait_blk(cyc, ok);
            checks++;
            if (!ok || cyc != 1) begin
                errors++;
                $display("FAIL stall_blk%0d_latency: got %0d cycles (valid=%b) want 1", b + 1, cyc, ok);
            end
            for (int s = 0; s < 5; s++) begin
                in_data  = 8'hEE;
                in_valid = 1'b1;
                in_last  = 1'b1;
                tick();
                checks++;
                if (blk_data !== exp || {blk_valid, in_ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL stall_blk%0d_hold: cycle %0d got %h valid/ready %b want %h 10",
                             b + 1, s, blk_data, {blk_valid, in_ready}, exp);
                end
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            checks++;
            if ({blk_first, blk_last} !== (b == 0 ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL stall_blk%0d_flags: got %b want %b", b + 1, {blk_first, blk_last},
                         (b == 0 ? 2'b10 : 2'b01));
            end
            take_blk();
            exp = '0;
            exp[7:0]     = 8'h80;
            exp[463:456] = 8'h02;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got in_ready %b want 1", in_ready);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++)
            send(8'h55, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (blk_data !== 512'b0 || {in_ready, blk_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_state: got %h ready/valid %b want 0 10", blk_data, {in_ready, blk_valid});
        end
        test_abc("abc_after_reset");
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_empty  = 1'b0;
        blk_ready = 1'b0;
        test_reset();
        test_empty();
        test_abc("abc");
        test_len55();
        test_len56();
        test_back_to_back_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md5_pad_feeder.md
# md5_pad_feeder

Message-side producer for the MD5 core block. Accepts an arbitrary-length message one byte per cycle, applies MD5 padding (0x80 marker, zero fill, 64-bit little-endian bit length), and hands complete 512-bit blocks to the core over a valid/ready handshake. It sits between the byte-stream source and the core's `data_in` / `enable` / `prepare_next_hash` inputs.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 8: message byte.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: qualifies `in_data` as the final message byte.
- `in_empty` in 1: sampled with `in_valid` and `in_last`. When 1, it marks a zero-length message and `in_data` is ignored.
- `in_ready` out 1: byte accepted on a cycle where `in_valid && in_ready`.
- `blk_data` out 512: message byte k of the block is at bits [8k+7:8k].
- `blk_valid` out 1: `blk_data` is valid and is held stable until accepted.
- `blk_ready` in 1: consumer takes the block on a cycle where `blk_valid && blk_ready`.
- `blk_first` out 1: this is the first block of a message. The consumer asserts `prepare_next_hash` for it.
- `blk_last` out 1: this is the final padded block of the message.

## Operation
- State machine: FILL, PAD, EMIT, EXTRA. Reset state is FILL.
- **FILL**
  - `in_ready`=1. Each accepted byte is written to byte index `idx`; then `idx`++ and `byte_cnt`++.
  - Accepted byte with `idx`=63 and `in_last`=0: go to EMIT (non-final), then return to FILL with `idx`=0.
  - Accepted byte with `in_last`=1, or `in_empty`=1: go to PAD.
- **PAD** (one cycle, `in_ready`=0). Let p = the index after the last byte.
  - p ≤ 55: byte p=0x80, bytes p+1..55=0, bytes 56..63 = `byte_cnt`×8 (little-endian). Go to EMIT with final=1.
  - 56 ≤ p ≤ 63: byte p=0x80, bytes p+1..63=0. Go to EMIT with final=0, then EXTRA.
  - p=64 (last byte filled the block): emit the block unchanged with final=0, then EXTRA with byte 0=0x80.
- **EXTRA** (one cycle): bytes = 0, except 0x80 at byte 0 when p=64, and the length at bytes 56..63. Go to EMIT with final=1.
- **EMIT**
  - `blk_valid`=1 and `in_ready`=0.
  - On `blk_ready`: if final, clear `byte_cnt`, `idx` and the buffer, and go to FILL. Otherwise continue per the pending path (FILL or EXTRA).
- `blk_first` = 1 on the first emitted block after reset or after a final block.
- Length arithmetic: bit length = `byte_cnt` << 3, modulo 2^64.
- `in_valid` while `in_ready`=0 is ignored. `in_last` without `in_valid` is ignored.

## Timing
- Reset values: `in_ready`=1, `blk_valid`=0, `blk_first`=0, `blk_last`=0, `blk_data`=0, `idx`=0, `byte_cnt`=0.
- Throughput: 1 byte/cycle in FILL. `blk_valid` rises the cycle after the 64th byte is accepted.
- Final block latency: last byte accepted at cycle t → PAD at t+1 → `blk_valid` at t+2. Add 2 cycles (EMIT handoff + EXTRA) when a second block is needed.
- `blk_data`, `blk_first` and `blk_last` are constant while `blk_valid && !blk_ready`.
- Reset at any cycle, including mid-FILL or mid-EMIT: the partial message is discarded and outputs go to reset values on the next edge.

## Configuration
- `MD5_PAD_FULL_LEN_EN`
  - Defined: `byte_cnt` is 61 bits, giving the full 64-bit MD5 length field.
  - Undefined: `byte_cnt` is 29 bits (messages < 512 MiB). Bytes 60..63 of the length field are driven 0. Counter overflow wraps silently.

## Test plan
- Empty message (`in_valid`=`in_last`=`in_empty`=1) → one block: byte0=0x80, all other bytes 0, `blk_first`=`blk_last`=1.
- "abc" (0x61,0x62,0x63, last on 0x63) → one block: bytes 0..3 = 61 62 63 80, byte56=0x18, others 0. Feeding this to the core yields hash 900150983cd24fb0d6963f7d28e17f72.
- 55 bytes of 0x41 → one block: byte55=0x80, byte56=0xB8, byte57=0x01.
- 56 bytes of 0x41 → block 1: byte56=0x80, `blk_last`=0. Block 2: zeros with byte56=0xC0, byte57=0x01, `blk_last`=1.
- 64 bytes, with `blk_ready` held low 5 cycles on each block → `blk_data` stable while stalled and `in_ready`=0. Block 2: byte0=0x80, byte57=0x02.
- Reset after 30 bytes, then send "abc" → output is identical to the "abc" case, with `blk_first`=1.
